failure_tally: RTL and testbench

FAILURE_TALLY -- requirements
Module: failure_tally

---
 rtl/failure_tally.sv | 76 +++++++
 tb/tb_failure_tally.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/failure_tally.sv
// failure_tally: counts failing RAM checks whose compare-tree result arrives TREE_LATENCY cycles late.
module failure_tally #(
  parameter int ADDR_WIDTH   = 10,
  parameter int COUNT_WIDTH  = 16,
  parameter int TREE_LATENCY = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   check_valid,
  input  logic [ADDR_WIDTH-1:0]  check_addr,
  input  logic                   check_last,
  input  logic                   error,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] fail_count,
  output logic                   any_fail,
  output logic [ADDR_WIDTH-1:0]  first_fail_addr
);
  typedef enum logic [1:0] {IDLE, COUNT, DRAIN, DONE} state_t;
  localparam int AL = TREE_LATENCY * ADDR_WIDTH;
  state_t state_q, state_d;
  logic [TREE_LATENCY-1:0] vld_q, vld_d, lst_q, lst_d;
  logic [AL-1:0] adr_q, adr_d;
  logic busy_q, busy_d, done_q, done_d, any_q, any_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ffa_q, ffa_d;
  logic accept, clear, fail, last_ev;
  always_comb begin
    accept  = check_valid && state_q == COUNT;
    clear   = start && (state_q == IDLE || state_q == DONE);
    fail    = vld_q[TREE_LATENCY-1] && error;
    last_ev = vld_q[TREE_LATENCY-1] && lst_q[TREE_LATENCY-1];
    // the delay line shifts toward the MSB; the MSB entry is the one being evaluated
    vld_d   = TREE_LATENCY'({vld_q, accept});
    lst_d   = TREE_LATENCY'({lst_q, accept && check_last});
    adr_d   = AL'({adr_q, check_addr});
    state_d = clear                                      ? COUNT
            : (state_q == COUNT && accept && check_last) ? DRAIN
            : (state_q == DRAIN && last_ev)              ? DONE
            : state_q;
    busy_d  = state_d == COUNT || state_d == DRAIN;
    done_d  = state_d == DONE;
    cnt_d   = clear ? '0 : (fail && cnt_q != '1) ? cnt_q + COUNT_WIDTH'(1) : cnt_q;
    any_d   = !clear && (any_q || fail);
    ffa_d   = clear ? '0 : (fail && !any_q) ? adr_q[AL-1 -: ADDR_WIDTH] : ffa_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      vld_q   <= '0;
      lst_q   <= '0;
      adr_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      any_q   <= 1'b0;
      cnt_q   <= '0;
      ffa_q   <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      lst_q   <= lst_d;
      adr_q   <= adr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      any_q   <= any_d;
      cnt_q   <= cnt_d;
      ffa_q   <= ffa_d;
    end
  end
  assign busy            = busy_q;
  assign done            = done_q;
  assign fail_count      = cnt_q;
  assign any_fail        = any_q;
  assign first_fail_addr = ffa_q;
endmodule

// File: tb/tb_failure_tally.sv
// tb_failure_tally: directed vector table plus hand-written pass sequences for failure_tally.
module tb_failure_tally;
  logic clk = 1'b0;
  logic reset, start, check_valid, check_last, error;
  logic [9:0] check_addr;
  logic busy, done, any_fail;
  logic [15:0] fail_count;
  logic [9:0] first_fail_addr;
  logic busy4, done4, any4;
  logic [3:0] cnt4;
  logic [9:0] ffa4;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  failure_tally dut (
    .clk(clk), .reset(reset), .start(start), .check_valid(check_valid),
    .check_addr(check_addr), .check_last(check_last), .error(error),
    .busy(busy), .done(done), .fail_count(fail_count), .any_fail(any_fail),
    .first_fail_addr(first_fail_addr)
  );

  failure_tally #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .check_valid(check_valid),
    .check_addr(check_addr), .check_last(check_last), .error(error),
    .busy(busy4), .done(done4), .fail_count(cnt4), .any_fail(any4),
    .first_fail_addr(ffa4)
  );

  typedef struct {
    logic s, cv;
    logic [9:0] a;
    logic l, e;
    logic b, d;
    logic [15:0] c;
    logic any;
    logic [9:0] f;
  } vec_t;

  function automatic logic [28:0] obs();
    return {busy, done, fail_count, any_fail, first_fail_addr};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, got, exp);
    end
  endtask

  task automatic step(input logic s, input logic cv, input logic [9:0] a, input logic l, input logic e);
    start = s; check_valid = cv; check_addr = a; check_last = l; error = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    // {start, valid, addr, last, error} -> {busy, done, count, any, first}
    tbl.push_back('{1'b0, 1'b1, 10'd3, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b0, 1'b1, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b0, 1'b1, 10'd1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b0, 1'b1, 10'd2, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b0, 1'b1, 10'd3, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b0, 1'b1, 10'd4, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 10'd0});
    tbl.push_back('{1'b0, 1'b1, 10'd5, 1'b0, 1'b1, 1'b1, 1'b0, 16'd1, 1'b1, 10'd2});
    tbl.push_back('{1'b0, 1'b1, 10'd6, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 10'd2});
    tbl.push_back('{1'b0, 1'b1, 10'd7, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 1'b1, 10'd2});
    tbl.push_back('{1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd2, 1'b1, 10'd2});
    tbl.push_back('{1'b0, 1'b1, 10'd9, 1'b0, 1'b0, 1'b1, 1'b0, 16'd2, 1'b1, 10'd2});
    tbl.push_back('{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 10'd2});
    tbl.push_back('{1'b0, 1'b0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 10'd2});
    tbl.push_back('{1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b1, 10'd2});
    tbl.push_back('{1'b0, 1'b1, 10'd8, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2, 1'b1, 10'd2});
    tbl.push_back('{1'b0, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'd2, 1'b1, 10'd2});

    reset = 1'b1;
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 10'd1, 1'b1, 1'b1);
    chk("reset", {3'b0, obs()}, 32'd0);
    chk("reset_w4", {busy4, done4, cnt4, any4, ffa4}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].s, tbl[i].cv, tbl[i].a, tbl[i].l, tbl[i].e);
      chk($sformatf("vec%0d", i), {3'b0, obs()},
          {3'b0, tbl[i].b, tbl[i].d, tbl[i].c, tbl[i].any, tbl[i].f});
    end

    // all-passing pass of 16 checks, then done held while idle
    step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("restart_clear", {3'b0, obs()}, {3'b0, 1'b1, 1'b0, 16'd0, 1'b0, 10'd0});
    for (int k = 0; k < 16; k++) step(1'b0, 1'b1, 10'(k), k == 15, 1'b0);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("pass16_drain", {30'b0, busy, done}, 32'd2);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("pass16_done", {3'b0, obs()}, {3'b0, 1'b0, 1'b1, 16'd0, 1'b0, 10'd0});
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
      chk($sformatf("pass16_hold%0d", k), {3'b0, obs()}, {3'b0, 1'b0, 1'b1, 16'd0, 1'b0, 10'd0});
    end

    // 20 failing checks: 4-bit counter saturates
    step(1'b1, 1'b0, 10'd0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b1, 10'(100 + k), k == 19, 1'b1);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    chk("sat_w4", {done4, cnt4, any4, ffa4}, {1'b1, 4'd15, 1'b1, 10'd100});
    chk("sat_w16", {3'b0, obs()}, {3'b0, 1'b0, 1'b1, 16'd20, 1'b1, 10'd100});

    // three failures, then restart from DONE into a single-check pass
    step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 10'(20 + k), k == 2, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    chk("three_fail", {3'b0, obs()}, {3'b0, 1'b0, 1'b1, 16'd3, 1'b1, 10'd20});
    step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("done_restart", {3'b0, obs()}, {3'b0, 1'b1, 1'b0, 16'd0, 1'b0, 10'd0});
    step(1'b0, 1'b1, 10'd42, 1'b1, 1'b0);
    step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    chk("single_wait", {30'b0, busy, done}, 32'd2);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    chk("single_done", {3'b0, obs()}, {3'b0, 1'b0, 1'b1, 16'd1, 1'b1, 10'd42});

    // reset two cycles after a failing check enters, with start asserted too
    step(1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 10'd7, 1'b0, 1'b0);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 1'b1, 10'd5, 1'b0, 1'b0);
    reset = 1'b0;
    chk("midpass_reset", {3'b0, obs()}, 32'd0);
    step(1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    chk("reset_err_ignored", {3'b0, obs()}, 32'd0);
    step(1'b0, 1'b1, 10'd6, 1'b1, 1'b1);
    chk("reset_idle", {3'b0, obs()}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
